pipe_reg_stage: RTL and testbench

Generic parametrised pipeline register replacing the hand-written per-stage latches between IF/ID/EX/MEM/WB. Carries a WIDTH-bit payload with a valid/ready handshake in both directions, honours the global `rdy` freeze, supports a synchronous flush that inserts a bubble, and optionally includes a one-entry skid buffer so `in_ready` never depends combinationally on `out_ready`. One instance sits between each pair of adjacent pipeline stages; stall propagates through back-pressure rather than a shared `stall_enable`.

---
 rtl/pipe_reg_stage_if.sv | 25 ++
 rtl/pipe_reg_stage.sv | 133 +++++++++++++
 tb/tb_pipe_reg_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_stage_if.sv
// Handshake bundle for one pipeline register stage: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy readout.
interface pipe_reg_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  // Driver/observer side (upstream producer plus downstream consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  // The register stage itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_stage.sv
// Generic pipeline register between adjacent stages. SKID=1 adds a second
// entry so in_ready is a function of held state only; SKID=0 is a single
// register whose in_ready looks through to out_ready. rdy=0 freezes
// everything, flush empties the stage and exposes the BUBBLE encoding.
module pipe_reg_stage #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  input logic             flush,
  pipe_reg_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             in_ready_w;
  logic [1:0]       count_w;
  logic             in_fire;
  logic             out_fire;

  // A transfer only happens when the global rdy is high.
  assign in_fire  = bus.in_valid & in_ready_w & rdy;
  assign out_fire = main_valid & bus.out_ready & rdy;

  generate
    if (SKID) begin : g_skid
      state_t           state_reg, state_next;
      logic [WIDTH-1:0] main_data_reg, main_data_next;
      logic [WIDTH-1:0] skid_data_reg, skid_data_next;

      // Next-state: main is always the head, skid only holds the entry
      // that arrived while downstream stalled. Flush overrides everything.
      always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        case (state_reg)
          EMPTY: begin
            if (in_fire) begin
              main_data_next = bus.in_data;
              state_next     = ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_data_next = bus.in_data;
            end else if (in_fire) begin
              skid_data_next = bus.in_data;
              state_next     = FULL;
            end else if (out_fire) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_data_next = skid_data_reg;
              state_next     = ONE;
            end
          end
          default: state_next = EMPTY;
        endcase
        if (flush) begin
          state_next = EMPTY;
        end
      end

      // State register; payload registers need no reset because the
      // state alone decides whether they are visible.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= EMPTY;
        end else begin
          state_reg <= state_next;
        end
        main_data_reg <= main_data_next;
        skid_data_reg <= skid_data_next;
      end

      assign main_valid = (state_reg != EMPTY);
      assign main_data  = main_data_reg;
      assign in_ready_w = !rst && (state_reg != FULL);
      assign count_w    = 2'(state_reg);
    end else begin : g_single
      logic             main_valid_reg, main_valid_next;
      logic [WIDTH-1:0] main_data_reg, main_data_next;

      // Load on accept, clear on drain without refill, empty on flush.
      always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        if (in_fire) begin
          main_valid_next = 1'b1;
          main_data_next  = bus.in_data;
        end else if (out_fire) begin
          main_valid_next = 1'b0;
        end
        if (flush) begin
          main_valid_next = 1'b0;
        end
      end

      // Single holding register.
      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid_reg <= 1'b0;
        end else begin
          main_valid_reg <= main_valid_next;
        end
        main_data_reg <= main_data_next;
      end

      assign main_valid = main_valid_reg;
      assign main_data  = main_data_reg;
      assign in_ready_w = !rst && (!main_valid_reg || bus.out_ready);
      assign count_w    = {1'b0, main_valid_reg};
    end
  endgenerate

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_valid ? main_data : BUBBLE;
  assign bus.count     = count_w;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Bench for pipe_reg_stage: one SKID=1 and one SKID=0 instance driven with
// identical stimulus. Each instance is tracked by a payload queue whose
// capacity and ready rule come straight from the handshake rules; outputs
// are compared every cycle, plus explicit vector tables and sequences.
module tb_pipe_reg_stage;
  localparam int W = 32;
  localparam logic [W-1:0] BUB = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  always #5 clk = ~clk;

  pipe_reg_stage_if #(.WIDTH(W)) bus1();
  pipe_reg_stage_if #(.WIDTH(W)) bus0();

  pipe_reg_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus1)
  );
  pipe_reg_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus0)
  );

  int total = 0;
  int passed = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic         cur_iv, cur_ordy;
  logic [W-1:0] cur_id;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         r;
    logic         fl;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   cnt;
    logic         eir;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply inputs after the falling edge, then compare both DUTs with the queues.
  task automatic drive(input logic rs, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic r, input logic fl);
    logic exp_ir1, exp_ir0;
    @(negedge clk);
    rst = rs; rdy = r; flush = fl;
    cur_iv = iv; cur_id = id; cur_ordy = ordy;
    bus1.in_valid = iv; bus1.in_data = id; bus1.out_ready = ordy;
    bus0.in_valid = iv; bus0.in_data = id; bus0.out_ready = ordy;
    #1;
    exp_ir1 = !rs && (q1.size() < 2);
    exp_ir0 = !rs && (q0.size() == 0 || ordy);
    chk("skid1.in_ready",  W'(bus1.in_ready),  W'(exp_ir1));
    chk("skid1.out_valid", W'(bus1.out_valid), W'(q1.size() > 0));
    chk("skid1.out_data",  bus1.out_data,      (q1.size() > 0) ? q1[0] : BUB);
    chk("skid1.count",     W'(bus1.count),     W'(q1.size()));
    chk("skid0.in_ready",  W'(bus0.in_ready),  W'(exp_ir0));
    chk("skid0.out_valid", W'(bus0.out_valid), W'(q0.size() > 0));
    chk("skid0.out_data",  bus0.out_data,      (q0.size() > 0) ? q0[0] : BUB);
    chk("skid0.count",     W'(bus0.count),     W'(q0.size()));
  endtask

  // Advance one clock and update the queues from the handshake rules.
  task automatic edge_step();
    logic if1, of1, if0, of0;
    if1 = cur_iv && !rst && (q1.size() < 2) && rdy;
    of1 = (q1.size() > 0) && cur_ordy && rdy;
    if0 = cur_iv && !rst && (q0.size() == 0 || cur_ordy) && rdy;
    of0 = (q0.size() > 0) && cur_ordy && rdy;
    if (of1) $display("t=%0t skid1 out %h", $time, q1[0]);
    @(posedge clk);
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (of1) void'(q1.pop_front());
      if (if1) q1.push_back(cur_id);
      if (of0) void'(q0.pop_front());
      if (if0) q0.push_back(cur_id);
    end
  endtask

  initial begin
    // Back-pressure, flush, flush-with-accept and rdy-freeze sequence for SKID=1
    tbl[0]  = '{1'b1, 32'hA,  1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[1]  = '{1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 32'hC,  1'b1, 1'b1, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 32'hC,  1'b1, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hC, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[7]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[8]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[13] = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[14] = '{1'b1, 32'h66, 1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[16] = '{1'b1, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[17] = '{1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 2'd1, 1'b1};
    tbl[18] = '{1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 2'd1, 1'b1};
    tbl[19] = '{1'b1, 32'h88, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 2'd1, 1'b1};
    tbl[20] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h88, 2'd1, 1'b1};
    tbl[21] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};

    // Unchecked first edge brings both instances out of power-up X.
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    cur_iv = 1'b1; cur_id = 32'hDEADBEEF; cur_ordy = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 32'hDEADBEEF; bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 32'hDEADBEEF; bus0.out_ready = 1'b0;
    @(posedge clk);

    // Reset held with a valid payload offered; nothing may be captured.
    drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    chk("reset.in_ready", W'(bus1.in_ready), W'(1'b0));
    chk("reset.out_data", bus1.out_data, BUB);
    edge_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("post_reset.in_ready", W'(bus1.in_ready), W'(1'b1));
    chk("post_reset.count", W'(bus1.count), W'(2'd0));
    edge_step();

    // Streaming 1..8 with out_ready high: one-cycle latency, count stays 1.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, (i <= 8), W'(i), 1'b1, 1'b1, 1'b0);
      if (i >= 2) begin
        chk("stream.out_data", bus1.out_data, W'(i - 1));
        chk("stream.count", W'(bus1.count), W'(2'd1));
      end
      edge_step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    edge_step();

    // Table: constant expectations for the SKID=1 instance.
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].r, tbl[i].fl);
      $display("vec %0d: in %b/%h ordy=%b rdy=%b flush=%b -> out %b/%h cnt=%0d ir=%b",
               i, tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].r, tbl[i].fl,
               bus1.out_valid, bus1.out_data, bus1.count, bus1.in_ready);
      chk($sformatf("vec%0d.out_valid", i), W'(bus1.out_valid), W'(tbl[i].ev));
      chk($sformatf("vec%0d.out_data", i),  bus1.out_data,      tbl[i].ed);
      chk($sformatf("vec%0d.count", i),     W'(bus1.count),     W'(tbl[i].cnt));
      chk($sformatf("vec%0d.in_ready", i),  W'(bus1.in_ready),  W'(tbl[i].eir));
      edge_step();
    end

    // SKID=0: blocked while full and stalled, then replaced in one cycle.
    drive(1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
    edge_step();
    drive(1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
    chk("single.blocked_in_ready", W'(bus0.in_ready), W'(1'b0));
    edge_step();
    drive(1'b0, 1'b1, 32'h6, 1'b1, 1'b1, 1'b0);
    chk("single.pass_in_ready", W'(bus0.in_ready), W'(1'b1));
    chk("single.old_data", bus0.out_data, 32'h5);
    edge_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("single.new_data", bus0.out_data, 32'h6);
    chk("single.count", W'(bus0.count), W'(2'd1));
    edge_step();

    // Randomized traffic against the queue models.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 70), $urandom(),
            ($urandom_range(99, 0) < 60), ($urandom_range(99, 0) < 90),
            ($urandom_range(99, 0) < 5));
      edge_step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
